hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. Decides each cycle whether the PC and the IF/ID register load, hold or flush, and whether ID/EX and EX/MEM take a bubble. It detects load-use hazards from ID/EX and IF/ID fields, flushes on taken branches resolved in MEM, and freezes the whole pipeline while data memory is busy. A bounded-wait counter flags memory stalls that run too long.

---
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline-side fields in, hold/flush controls and status out.
// master = pipeline datapath, slave = hazard_ctrl.
interface hazard_ctrl_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs2;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        branch_taken;
    logic        mem_wait;

    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        pipe_freeze;
    logic        mem_timeout;
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
               branch_taken, mem_wait,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
               pipe_freeze, mem_timeout, stall_cycles, flush_events
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
               branch_taken, mem_wait,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
               pipe_freeze, mem_timeout, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze > branch flush > load-use bubble > run, plus a memory-wait
// watchdog. Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STALL  = 2'd2,
        ST_SHADOW = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic lu;
    logic frz_act, br_act, lu_act;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze;

    assign lu = hz.ex_mem_read && (hz.ex_rd != 5'd0) && hz.id_valid &&
                ((hz.ex_rd == hz.id_rs1) || (hz.id_uses_rs2 && (hz.ex_rd == hz.id_rs2)));

    // A branch seen in the cycle right after an accepted one comes from a flushed slot.
    assign frz_act = hz.mem_wait;
    assign br_act  = !frz_act && hz.branch_taken && (state_q != ST_SHADOW);
    assign lu_act  = !frz_act && !br_act && lu;

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_freeze  = 1'b0;
        state_d      = ST_RUN;

        if (frz_act) begin
            pipe_freeze = 1'b1;
            state_d     = ST_WAIT;
        end else if (br_act) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = ST_SHADOW;
        end else if (lu_act) begin
            id_ex_flush = 1'b1;
            state_d     = ST_STALL;
        end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
        end

        // Hold everything quiet while reset is asserted.
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
            pipe_freeze  = 1'b0;
        end
    end

    always_comb begin
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        if (hz.mem_wait) begin
            if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
                wait_cnt_d    = wait_cnt_q;
                mem_timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + ((frz_act || lu_act) ? 32'd1 : 32'd0);
        flush_events_d = flush_events_q + (br_act ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_events = flush_events_q;
`else
    assign hz.stall_cycles = 32'd0;
    assign hz.flush_events = 32'd0;
`endif

    assign hz.pc_write     = pc_write;
    assign hz.if_id_write  = if_id_write;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_flush = ex_mem_flush;
    assign hz.pipe_freeze  = pipe_freeze;
    assign hz.mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MAX_WAIT=4; counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze}
    localparam logic [5:0] C_RUN = 6'b110000;
    localparam logic [5:0] C_BR  = 6'b111110;
    localparam logic [5:0] C_LU  = 6'b000100;
    localparam logic [5:0] C_FRZ = 6'b000001;
    localparam logic [5:0] C_OFF = 6'b000000;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MAX_WAIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    logic [5:0] ctl;
    assign ctl = {hz.pc_write, hz.if_id_write, hz.if_id_flush,
                  hz.id_ex_flush, hz.ex_mem_flush, hz.pipe_freeze};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_ctl(input string tag, input logic [5:0] exp);
        check(tag, {26'd0, ctl}, {26'd0, exp});
    endtask

    task automatic check_cnt(input string tag, input int stalls, input int flushes);
`ifdef HAZARD_PERF_CNT_EN
        check({tag, "_stall"}, hz.stall_cycles, stalls);
        check({tag, "_flush"}, hz.flush_events, flushes);
`else
        check({tag, "_stall"}, hz.stall_cycles, 32'd0);
        check({tag, "_flush"}, hz.flush_events, 32'd0);
        if (stalls < 0 || flushes < 0) $display("negative count request");
`endif
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        hz.id_valid     = 1'b0;
        hz.id_rs1       = 5'd0;
        hz.id_rs2       = 5'd0;
        hz.id_uses_rs2  = 1'b0;
        hz.ex_mem_read  = 1'b0;
        hz.ex_rd        = 5'd0;
        hz.branch_taken = 1'b0;
        hz.mem_wait     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total  = 0;
        passed = 0;
        idle_inputs();
        reset = 1'b1;
        #1;
        check_ctl("reset_ctl", C_OFF);
        check("reset_timeout", {31'd0, hz.mem_timeout}, 32'd0);
        check_cnt("reset_cnt", 0, 0);
        step();
        step();
        reset = 1'b0;
        #1 check_ctl("idle_run", C_RUN);

        // Load-use on rs2, one bubble then run.
        step();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rs2 = 5'd5;
        hz.id_uses_rs2 = 1'b1; hz.id_valid = 1'b1; hz.id_rs1 = 5'd3;
        #1 check_ctl("lu_rs2", C_LU);
        step();
        hz.ex_mem_read = 1'b0;
        #1 check_ctl("lu_after", C_RUN);
        step();
        hz.ex_mem_read = 1'b1; hz.id_uses_rs2 = 1'b0;
        #1 check_ctl("lu_rs2_unused", C_RUN);
        step();
        hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0;
        #1 check_ctl("x0_immune", C_RUN);

        // Back-to-back load-use via rs1 inserts two bubbles.
        step();
        hz.ex_rd = 5'd7; hz.id_rs1 = 5'd7;
        #1 check_ctl("lu_rs1_a", C_LU);
        step();
        #1 check_ctl("lu_rs1_b", C_LU);

        // Branch with concurrent load-use: branch wins; shadow cycle ignores the repeat.
        step();
        hz.branch_taken = 1'b1;
        #1 check_ctl("br_over_lu", C_BR);
        step();
        hz.ex_mem_read = 1'b0;
        #1 check_ctl("br_shadow", C_RUN);
        step();
        hz.branch_taken = 1'b0;
        #1 check_cnt("cnt_a", 3, 1);

        // Freeze for 3 cycles with branch held, then the branch flushes.
        hz.mem_wait = 1'b1; hz.branch_taken = 1'b1;
        #1 check_ctl("frz_1", C_FRZ);
        step();
        #1 check_ctl("frz_2", C_FRZ);
        step();
        #1 check_ctl("frz_3", C_FRZ);
        step();
        hz.mem_wait = 1'b0;
        #1 check_ctl("frz_then_br", C_BR);
        step();
        hz.branch_taken = 1'b0;
        #1 check_ctl("frz_br_done", C_RUN);
        check("timeout_after_3", {31'd0, hz.mem_timeout}, 32'd0);
        check_cnt("cnt_b", 6, 2);

        // Two 4-cycle waits separated by an idle cycle stay under the limit.
        for (int r = 0; r < 2; r++) begin
            step();
            hz.mem_wait = 1'b1;
            repeat (4) step();
            hz.mem_wait = 1'b0;
            #1 check("timeout_4_waits", {31'd0, hz.mem_timeout}, 32'd0);
        end

        // Five consecutive waits trip the sticky timeout.
        step();
        hz.mem_wait = 1'b1;
        repeat (4) step();
        #1 check("timeout_before_5th", {31'd0, hz.mem_timeout}, 32'd0);
        step();
        hz.mem_wait = 1'b0;
        #1 check("timeout_5_waits", {31'd0, hz.mem_timeout}, 32'd1);
        check_ctl("timeout_ctl_run", C_RUN);
        step();
        step();
        #1 check("timeout_sticky", {31'd0, hz.mem_timeout}, 32'd1);
        check_cnt("cnt_c", 19, 2);

        // Asynchronous reset in the middle of a freeze.
        hz.mem_wait = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_ctl("rst_mid_ctl", C_OFF);
        check("rst_mid_timeout", {31'd0, hz.mem_timeout}, 32'd0);
        check_cnt("rst_mid_cnt", 0, 0);
        step();
        hz.mem_wait = 1'b0;
        reset = 1'b0;
        hz.branch_taken = 1'b1;
        #1 check_ctl("post_rst_br", C_BR);
        step();
        idle_inputs();
        #1 check_ctl("post_rst_run", C_RUN);
        check_cnt("post_rst_cnt", 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
